// File: rtl/csa_stream_sequencer.sv
// csa_stream_sequencer: sequences 64-bit CSA blocks through an external
// stream cypher, one block in flight, with packet framing and error pulses.
// Ports: clk/rst_n (sync, active-low); in_* valid/ready block input;
// out_* valid/ready block output; sc_sb/sc_ck seed and key to the cypher,
// sc_cb keystream back; err one-cycle protocol pulse; busy = not IDLE.
module csa_stream_sequencer #(
  parameter int SC_LAT     = 3,
  parameter int MAX_BLOCKS = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] ck_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_first,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_first,
  output logic        out_last,
  output logic [63:0] sc_sb,
  output logic [63:0] sc_ck,
  input  logic [63:0] sc_cb,
  output logic        err,
  output logic        busy
);

  localparam int CW = $clog2(MAX_BLOCKS + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BLOCKS);
  localparam logic ONE_BLK = (MAX_BLOCKS == 1);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    WAIT_IN,
    CALC
  } state_t;

  state_t        state, next;
  logic [63:0]   prev, cur;
  logic [CW-1:0] cnt;
  logic [3:0]    lat;
  logic          last_q;

  logic in_hs, out_hs;
  logic ld_first, ld_cur, ld_calc;
  logic drop, restart, cap;

  assign in_ready  = rst_n &&
                     (state == IDLE || state == WAIT_IN);
  assign out_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign sc_sb     = prev;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next     = state;
    ld_first = 1'b0;
    ld_cur   = 1'b0;
    ld_calc  = 1'b0;
    drop     = 1'b0;
    restart  = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_hs) begin
          if (in_first) begin
            ld_first = 1'b1;
            next     = EMIT;
          end else begin
            drop = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_hs) next = out_last ? IDLE : WAIT_IN;
      end
      WAIT_IN: begin
        if (in_hs) begin
          if (in_first) begin
            ld_first = 1'b1;
            restart  = 1'b1;
            next     = EMIT;
          end else begin
            ld_cur = 1'b1;
            next   = CALC;
          end
        end
      end
      CALC: begin
        if (lat == 4'd1) begin
          ld_calc = 1'b1;
          next    = EMIT;
        end
      end
      default: next = IDLE;
    endcase
  end

  // A block reaching the packet size cap without in_last is closed
  // by force; the first-block case only matters when the cap is one.
  always_comb begin
    cap = 1'b0;
    if (ld_cur && !in_last && (cnt + 1'b1 == MAXC))
      cap = 1'b1;
    if (ld_first && !in_last && ONE_BLK)
      cap = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev      <= '0;
      cur       <= '0;
      sc_ck     <= '0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      cnt       <= '0;
      lat       <= '0;
      last_q    <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= drop || restart || cap;
      if (ld_first) begin
        sc_ck     <= ck_in;
        prev      <= in_data;
        out_data  <= in_data;
        out_first <= 1'b1;
        out_last  <= in_last || ONE_BLK;
        cnt       <= CW'(1);
      end
      if (ld_cur) begin
        cur    <= in_data;
        cnt    <= cnt + 1'b1;
        lat    <= 4'(SC_LAT);
        last_q <= in_last || cap;
      end
      if (state == CALC && lat != 4'd0)
        lat <= lat - 4'd1;
      // Keystream for this block was seeded by the previous
      // scrambled block, which is still held in prev.
      if (ld_calc) begin
        out_data  <= cur ^ sc_cb;
        prev      <= cur;
        out_first <= 1'b0;
        out_last  <= last_q;
      end
    end
  end

endmodule

// File: tb/tb_csa_stream_sequencer.sv
// tb_csa_stream_sequencer: directed bench for csa_stream_sequencer
// with a keystream model of sc_sb XOR a fixed constant.
module tb_csa_stream_sequencer;

  localparam logic [63:0] C = 64'hFFFF0000FFFF0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] ck_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        out_first;
  logic        out_last;
  logic [63:0] sc_sb;
  logic [63:0] sc_ck;
  logic [63:0] sc_cb;
  logic        err;
  logic        busy;

  int checks = 0;
  int errs = 0;
  int err_cnt = 0;

  assign sc_cb = sc_sb ^ C;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && err) err_cnt <= err_cnt + 1;

  csa_stream_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ck_in(ck_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_first(in_first),
    .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last),
    .sc_sb(sc_sb), .sc_ck(sc_ck), .sc_cb(sc_cb),
    .err(err), .busy(busy)
  );

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic send(logic [63:0] d, logic f, logic l);
    int n = 0;
    @(negedge clk);
    in_data = d; in_first = f; in_last = l;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic recv(string tag, logic [63:0] d,
                      logic f, logic l, int lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 30);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_first"}, 64'(out_first), 64'(f));
    chk({tag, "_last"}, 64'(out_last), 64'(l));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] b0, b1, b2, d0, hold, p, dat;
    int e0, e1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready_rel", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_sc_sb", sc_sb, 64'd0);
    chk("rst_sc_ck", sc_ck, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // single-block packet
    ck_in = 64'hA5A5_1234_5678_9ABC;
    send(64'h0123456789ABCDEF, 1'b1, 1'b1);
    recv("single", 64'h0123456789ABCDEF, 1'b1, 1'b1, 1);
    @(negedge clk);
    chk("single_idle", 64'(busy), 64'd0);
    chk("single_ck", sc_ck, 64'hA5A5_1234_5678_9ABC);

    // three-block packet; ck_in changes mid-packet are ignored
    b0 = 64'h1111_2222_3333_4444;
    b1 = 64'h5555_6666_7777_8888;
    b2 = 64'h9999_AAAA_BBBB_CCCC;
    ck_in = 64'h0F0F_0F0F_F0F0_F0F0;
    send(b0, 1'b1, 1'b0);
    recv("p3_b0", b0, 1'b1, 1'b0, 1);
    ck_in = 64'hDEAD_BEEF_DEAD_BEEF;
    chk("p3_sb", sc_sb, b0);
    send(b1, 1'b0, 1'b0);
    recv("p3_b1", b1 ^ b0 ^ C, 1'b0, 1'b0, 4);
    send(b2, 1'b0, 1'b1);
    recv("p3_b2", b2 ^ b1 ^ C, 1'b0, 1'b1, 4);
    chk("p3_ck_kept", sc_ck, 64'h0F0F_0F0F_F0F0_F0F0);

    // backpressure on the output
    d0 = 64'hCAFE_F00D_0BAD_BEEF;
    out_ready = 1'b0;
    send(d0, 1'b1, 1'b0);
    @(negedge clk);
    hold = out_data;
    chk("bp_hold_data0", hold, d0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data", out_data, hold);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1);
    recv("bp_b1", 64'h0000_0000_FFFF_FFFF ^ d0 ^ C,
         1'b0, 1'b1, 4);

    // protocol errors: stray non-first, then restart
    e0 = err_cnt;
    send(64'h7777_7777_7777_7777, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("drop_no_out", 64'(out_valid), 64'd0);
    end
    chk("drop_err", 64'(err_cnt), 64'(e0 + 1));
    chk("drop_busy", 64'(busy), 64'd0);
    ck_in = 64'h3333_0000_3333_0000;
    send(64'hAAAA_0000_0000_0001, 1'b1, 1'b0);
    recv("rs_e0", 64'hAAAA_0000_0000_0001, 1'b1, 1'b0, 1);
    chk("rs_ck0", sc_ck, 64'h3333_0000_3333_0000);
    ck_in = 64'h4444_5555_6666_7777;
    e1 = err_cnt;
    send(64'hBBBB_0000_0000_0002, 1'b1, 1'b0);
    recv("rs_e1", 64'hBBBB_0000_0000_0002, 1'b1, 1'b0, 1);
    chk("rs_err", 64'(err_cnt), 64'(e1 + 1));
    chk("rs_ck1", sc_ck, 64'h4444_5555_6666_7777);
    send(64'hCCCC_0000_0000_0003, 1'b0, 1'b1);
    recv("rs_e2", 64'hCCCC_0000_0000_0003 ^
         64'hBBBB_0000_0000_0002 ^ C, 1'b0, 1'b1, 4);

    // 24 blocks with no in_last: cap at 23
    e0 = err_cnt;
    p = '0;
    for (int i = 1; i <= 23; i++) begin
      dat = 64'h1357_9BDF_2468_ACE0 ^ (64'(i) << (8 * (i % 8)));
      if (i == 1) begin
        send(dat, 1'b1, 1'b0);
        recv("cap_b1", dat, 1'b1, 1'b0, 1);
      end else begin
        send(dat, 1'b0, 1'b0);
        recv($sformatf("cap_b%0d", i), dat ^ p ^ C,
             1'b0, (i == 23), 4);
      end
      if (i == 22) chk("cap_no_err", 64'(err_cnt), 64'(e0));
      p = dat;
    end
    chk("cap_err", 64'(err_cnt), 64'(e0 + 1));
    chk("cap_idle", 64'(busy), 64'd0);
    send(64'h2424_2424_2424_2424, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("b24_no_out", 64'(out_valid), 64'd0);
    end
    chk("b24_err", 64'(err_cnt), 64'(e0 + 2));

    // reset in the second CALC cycle
    send(64'h6666_0000_6666_0000, 1'b1, 1'b0);
    recv("rc_g0", 64'h6666_0000_6666_0000, 1'b1, 1'b0, 1);
    send(64'h0000_9999_0000_9999, 1'b0, 1'b1);
    @(negedge clk);
    chk("rc_calc_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rc_in_ready_rst", 64'(in_ready), 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rc_out_valid", 64'(out_valid), 64'd0);
      chk("rc_out_data", out_data, 64'd0);
      chk("rc_flags", {out_first, out_last, err, busy}, 64'd0);
      chk("rc_sc_sb", sc_sb, 64'd0);
      chk("rc_sc_ck", sc_ck, 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rc_in_ready_rel", 64'(in_ready), 64'd1);
    repeat (6) begin
      @(negedge clk);
      chk("rc_no_out", 64'(out_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
